// File: rtl/video_pkg.sv
// Shared video types and defaults for the background tile pipeline.
package video_pkg;

    localparam int TILE_W_DEF = 8;
    localparam int COL_W_DEF  = 4;

    typedef logic [1:0]           pixel_t;
    typedef logic [COL_W_DEF-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2
    } tile_state_e;

endpackage

// File: rtl/shift_plane.sv
// One bit-plane shifter: clear, parallel load or one-bit shift per pixel step.
// edge_bit is taken from the next register value so the caller can register it alongside.
module shift_plane
    import video_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load,
    input  logic [TILE_W-1:0] load_data,
    input  logic              step,
    input  logic              dir,
    output logic              edge_bit
);

    logic [TILE_W-1:0] q;
    logic [TILE_W-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        if (clear) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = load_data;
        end else if (step) begin
            q_nxt = dir ? (q >> 1) : (q << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    // dir=1 (mirrored tile) reads pixels from the LSB end
    assign edge_bit = dir ? q_nxt[0] : q_nxt[TILE_W-1];

endmodule

// File: rtl/tile_shifter.sv
// Background tile pixel serializer with a one-tile holding register and fetch handshake.
// Optional: TILE_SHIFTER_UNDERRUN_CNT_EN adds a saturating underrun event counter output.
//
// state | meaning
// IDLE  | waiting for the first line_start of a frame
// REQ   | holding register empty, fetch_req asserted (registered)
// FULL  | holding register valid, waiting for the tile boundary
module tile_shifter
    import video_pkg::*;
#(
    parameter int TILE_W = TILE_W_DEF,
    parameter int COL_W  = COL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h_half,
    input  logic              line_start,
    input  logic              flip_x,
    output logic              fetch_req,
    input  logic              fetch_ack,
    input  logic [TILE_W-1:0] plane0,
    input  logic [TILE_W-1:0] plane1,
    input  logic [COL_W-1:0]  color,
    output pixel_t            vid,
    output logic [COL_W-1:0]  col,
    output logic              underrun
`ifdef TILE_SHIFTER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]        underrun_cnt
`endif
);

    localparam int              PW        = $clog2(TILE_W);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(TILE_W - 1);
    localparam logic [1:0]      S_IDLE    = IDLE;
    localparam logic [1:0]      S_REQ     = REQ;
    localparam logic [1:0]      S_FULL    = FULL;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [PW-1:0]     pcnt;
    logic              flip;
    logic              flip_nxt;
    logic [TILE_W-1:0] hold0;
    logic [TILE_W-1:0] hold1;
    logic [COL_W-1:0]  hold_col;

    logic              step;
    logic              ls_step;
    logic              boundary;
    logic              in_req;
    logic              ack_take;
    logic              bypass;
    logic              underrun_ev;
    logic [TILE_W-1:0] ld0;
    logic [TILE_W-1:0] ld1;
    logic [COL_W-1:0]  ld_col;
    logic              e0;
    logic              e1;

    assign step     = ~h_half;
    assign ls_step  = step & line_start;
    assign boundary = step & ~line_start & (pcnt == PCNT_LAST);
    assign in_req   = (state == S_REQ);
    // an ack coinciding with a honoured line_start belongs to the old line
    assign ack_take = in_req & fetch_ack & ~ls_step;
    assign bypass   = boundary & ack_take;
    // before the first line_start nothing is on screen, so no underrun is reported
    assign underrun_ev = boundary & in_req & ~fetch_ack;

    always_comb begin
        ld0    = '0;
        ld1    = '0;
        ld_col = '0;
        if (bypass) begin
            ld0    = plane0;
            ld1    = plane1;
            ld_col = color;
        end else if (state == S_FULL) begin
            ld0    = hold0;
            ld1    = hold1;
            ld_col = hold_col;
        end
    end

    always_comb begin
        flip_nxt = flip;
        if (ls_step) begin
            flip_nxt = 1'b0;
        end else if (boundary) begin
            flip_nxt = flip_x;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ls_step) begin
            state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ:   if (fetch_ack && !boundary) state_nxt = S_FULL;
                S_FULL:  if (boundary) state_nxt = S_REQ;
                default: state_nxt = state;
            endcase
        end
    end

    shift_plane #(.TILE_W(TILE_W)) u_plane0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ls_step),
        .load      (boundary),
        .load_data (ld0),
        .step      (step),
        .dir       (flip_nxt),
        .edge_bit  (e0)
    );

    shift_plane #(.TILE_W(TILE_W)) u_plane1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ls_step),
        .load      (boundary),
        .load_data (ld1),
        .step      (step),
        .dir       (flip_nxt),
        .edge_bit  (e1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pcnt      <= '0;
            flip      <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
            hold_col  <= '0;
            fetch_req <= 1'b0;
            vid       <= '0;
            col       <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            flip      <= flip_nxt;
            fetch_req <= in_req & ~ack_take;
            underrun  <= underrun | underrun_ev;

            if (ls_step) begin
                pcnt <= '0;
            end else if (step) begin
                pcnt <= pcnt + PW'(1);
            end

            if (ls_step) begin
                hold0    <= '0;
                hold1    <= '0;
                hold_col <= '0;
            end else if (ack_take && !boundary) begin
                hold0    <= plane0;
                hold1    <= plane1;
                hold_col <= color;
            end

            if (step) begin
                vid <= {e1, e0};
            end

            if (ls_step) begin
                col <= '0;
            end else if (boundary) begin
                col <= ld_col;
            end
        end
    end

`ifdef TILE_SHIFTER_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= 8'd0;
        end else if (underrun_ev && (underrun_cnt != 8'hFF)) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_shifter.sv
// Self-checking bench for tile_shifter: directed scenarios plus randomized traffic against a pixel-array model.
module tb_tile_shifter;

    localparam int TW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h_half;
    logic          line_start;
    logic          flip_x;
    logic          fetch_req;
    logic          fetch_ack;
    logic [TW-1:0] plane0;
    logic [TW-1:0] plane1;
    logic [CW-1:0] color;
    logic [1:0]    vid;
    logic [CW-1:0] col;
    logic          underrun;
`ifdef TILE_SHIFTER_UNDERRUN_CNT_EN
    logic [7:0]    underrun_cnt;
`endif

    always #5 clk = ~clk;

    tile_shifter #(.TILE_W(TW), .COL_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_half     (h_half),
        .line_start (line_start),
        .flip_x     (flip_x),
        .fetch_req  (fetch_req),
        .fetch_ack  (fetch_ack),
        .plane0     (plane0),
        .plane1     (plane1),
        .color      (color),
        .vid        (vid),
        .col        (col),
        .underrun   (underrun)
`ifdef TILE_SHIFTER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: the tile on screen is an array of pixels indexed by screen position.
    logic [1:0]    m_pix [TW];
    logic [CW-1:0] m_col;
    int            m_idx;
    bit            m_active;
    bit            m_hold_valid;
    logic [TW-1:0] m_h0, m_h1;
    logic [CW-1:0] m_hc;
    bit            m_under;
    bit            m_req;
    int            m_ucnt;

    function automatic logic [1:0] tile_pix(input logic [TW-1:0] p0, input logic [TW-1:0] p1,
                                            input logic fx, input int k);
        int b;
        b = fx ? k : (TW - 1 - k);
        return {p1[b], p0[b]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TW; k++) m_pix[k] = 2'd0;
        m_col = '0; m_idx = 0; m_active = 0; m_hold_valid = 0;
        m_h0 = '0; m_h1 = '0; m_hc = '0;
        m_under = 0; m_req = 0; m_ucnt = 0;
    endtask

    task automatic model_show(input logic [TW-1:0] p0, input logic [TW-1:0] p1,
                              input logic [CW-1:0] c, input logic fx);
        for (int k = 0; k < TW; k++) m_pix[k] = tile_pix(p0, p1, fx, k);
        m_col = c;
    endtask

    task automatic model_update(input logic h, input logic ls, input logic ack,
                                input logic [TW-1:0] p0, input logic [TW-1:0] p1,
                                input logic [CW-1:0] c, input logic fx);
        bit step, ack_ok, new_req;
        step    = !h;
        ack_ok  = m_active && !m_hold_valid && ack && !(step && ls);
        new_req = m_active && !m_hold_valid && !ack_ok;
        if (step && ls) begin
            model_show('0, '0, '0, 1'b0);
            m_idx = 0; m_active = 1; m_hold_valid = 0;
        end else if (step && m_idx == TW - 1) begin
            if (m_hold_valid) begin
                model_show(m_h0, m_h1, m_hc, fx);
                m_hold_valid = 0;
            end else if (ack_ok) begin
                model_show(p0, p1, c, fx);
            end else begin
                model_show('0, '0, '0, fx);
                if (m_active) begin
                    m_under = 1;
                    if (m_ucnt < 255) m_ucnt++;
                end
            end
            m_idx = 0;
        end else begin
            if (step) m_idx++;
            if (ack_ok) begin
                m_h0 = p0; m_h1 = p1; m_hc = c; m_hold_valid = 1;
            end
        end
        m_req = new_req;
    endtask

    task automatic tick(input logic h, input logic ls, input logic ack,
                        input logic [TW-1:0] p0, input logic [TW-1:0] p1,
                        input logic [CW-1:0] c, input logic fx);
        @(negedge clk);
        h_half = h; line_start = ls; fetch_ack = ack;
        plane0 = p0; plane1 = p1; color = c; flip_x = fx;
        @(posedge clk);
        model_update(h, ls, ack, p0, p1, c, fx);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        h_half = 1'b1; line_start = 1'b0; fetch_ack = 1'b0; flip_x = 1'b0;
        plane0 = '0; plane1 = '0; color = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (vid !== 2'd0) begin n_err++; $display("FAIL reset_vid got %0d want 0", vid); end
        n_cmp++; if (col !== '0) begin n_err++; $display("FAIL reset_col got %0d want 0", col); end
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b want 0", fetch_req); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun got %0b want 0", underrun); end
    endtask

    // tbl holds the 8 expected pixels of the tile, first pixel in the top bits
    task automatic test_pattern(input logic fx, input logic [15:0] tbl);
        logic [1:0] want;
        tick(1'b1, 1'b0, 1'b0, '0, '0, '0, fx);
        tick(1'b0, 1'b1, 1'b0, '0, '0, '0, fx);
        tick(1'b1, 1'b0, 1'b1, 8'hF0, 8'hAA, 4'h3, fx);
        for (int s = 0; s < 16; s++) begin
            if (s > 0) begin
                tick(1'b1, 1'b0, 1'b0, '0, '0, '0, fx);
                tick(1'b0, 1'b0, 1'b0, '0, '0, '0, fx);
            end
            want = (s < TW) ? 2'd0 : tbl[15 - 2*(s-TW) -: 2];
            n_cmp++;
            if (vid !== want || vid !== m_pix[m_idx]) begin
                n_err++; $display("FAIL pattern_vid flip=%0b step=%0d got %0d want %0d", fx, s, vid, want);
            end
            n_cmp++;
            if (col !== m_col || (s >= TW && col !== 4'h3)) begin
                n_err++; $display("FAIL pattern_col flip=%0b step=%0d got %0d want %0d", fx, s, col, m_col);
            end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL pattern_underrun got %0b want 0", underrun); end
    endtask

    task automatic test_bypass();
        tick(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        for (int s = 1; s < TW; s++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL bypass_req_before got %0b want 1", fetch_req); end
        tick(1'b0, 1'b0, 1'b1, 8'h3C, 8'hC3, 4'h9, 1'b0);
        n_cmp++; if (vid !== 2'd2) begin n_err++; $display("FAIL bypass_vid got %0d want 2", vid); end
        n_cmp++; if (col !== 4'h9) begin n_err++; $display("FAIL bypass_col got %0d want 9", col); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL bypass_underrun got %0b want 0", underrun); end
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL bypass_req_drop got %0b want 0", fetch_req); end
        tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL bypass_req_again got %0b want 1", fetch_req); end
        for (int s = 1; s < TW; s++) begin
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            n_cmp++;
            if (vid !== m_pix[m_idx]) begin n_err++; $display("FAIL bypass_seq step=%0d got %0d want %0d", s, vid, m_pix[m_idx]); end
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_ls_ack();
        tick(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 4'hF, 1'b0);
        n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL lsack_req got %0b want 1", fetch_req); end
        n_cmp++; if (vid !== 2'd0 || col !== '0) begin n_err++; $display("FAIL lsack_clear got vid=%0d col=%0d want 0/0", vid, col); end
        for (int s = 1; s <= TW; s++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            n_cmp++; if (fetch_req !== 1'b1) begin n_err++; $display("FAIL lsack_req_hold step=%0d got %0b want 1", s, fetch_req); end
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            if (s == TW - 1) begin
                n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL lsack_early_underrun got %0b want 0", underrun); end
            end
        end
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL lsack_underrun got %0b want 1", underrun); end
        n_cmp++; if (vid !== 2'd0 || col !== '0) begin n_err++; $display("FAIL lsack_discard got vid=%0d col=%0d want 0/0", vid, col); end
    endtask

    task automatic test_underrun();
        apply_reset();
        tick(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 8'h0F, 8'h33, 4'h5, 1'b0);
        for (int s = 1; s <= 2*TW; s++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            if (s == TW) begin
                n_cmp++; if (col !== 4'h5) begin n_err++; $display("FAIL under_tile_col got %0d want 5", col); end
            end
        end
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL under_flag got %0b want 1", underrun); end
        n_cmp++; if (vid !== 2'd0 || col !== '0) begin n_err++; $display("FAIL under_zero got vid=%0d col=%0d want 0/0", vid, col); end
        tick(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 4'h2, 1'b0);
        for (int s = 1; s <= TW; s++) begin
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
        n_cmp++; if (col !== 4'h2) begin n_err++; $display("FAIL under_recover_col got %0d want 2", col); end
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL under_sticky got %0b want 1", underrun); end
    endtask

    task automatic test_random();
        logic h, ls, ack, fx;
        logic [TW-1:0] p0, p1;
        logic [CW-1:0] c;
        for (int i = 0; i < 600; i++) begin
            h   = 1'($urandom_range(0, 1));
            ls  = ($urandom_range(0, 39) == 0);
            ack = ($urandom_range(0, 2) == 0);
            fx  = 1'($urandom_range(0, 1));
            p0  = TW'($urandom);
            p1  = TW'($urandom);
            c   = CW'($urandom);
            tick(h, ls, ack, p0, p1, c, fx);
            n_cmp++; if (vid !== m_pix[m_idx]) begin n_err++; $display("FAIL rand_vid cyc=%0d got %0d want %0d", i, vid, m_pix[m_idx]); end
            n_cmp++; if (col !== m_col) begin n_err++; $display("FAIL rand_col cyc=%0d got %0d want %0d", i, col, m_col); end
            n_cmp++; if (fetch_req !== m_req) begin n_err++; $display("FAIL rand_req cyc=%0d got %0b want %0b", i, fetch_req, m_req); end
            n_cmp++; if (underrun !== m_under) begin n_err++; $display("FAIL rand_underrun cyc=%0d got %0b want %0b", i, underrun, m_under); end
`ifdef TILE_SHIFTER_UNDERRUN_CNT_EN
            n_cmp++; if (int'(underrun_cnt) != m_ucnt) begin n_err++; $display("FAIL rand_ucnt cyc=%0d got %0d want %0d", i, underrun_cnt, m_ucnt); end
`endif
        end
    endtask

    task automatic test_reset_midline();
        apply_reset();
        tick(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 4'h5, 1'b0);
        for (int s = 1; s <= TW; s++) begin
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b1, 8'h0F, 8'hF0, 4'h6, 1'b0);
        for (int s = 1; s <= 5; s++) begin
            tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
            tick(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        end
        n_cmp++; if (vid !== 2'd3 || col !== 4'h5) begin n_err++; $display("FAIL mid_pre got vid=%0d col=%0d want 3/5", vid, col); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (vid !== 2'd0) begin n_err++; $display("FAIL mid_vid got %0d want 0", vid); end
        n_cmp++; if (col !== '0) begin n_err++; $display("FAIL mid_col got %0d want 0", col); end
        n_cmp++; if (fetch_req !== 1'b0) begin n_err++; $display("FAIL mid_req got %0b want 0", fetch_req); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(1'(i % 2), 1'b0, 1'b1, 8'hFF, 8'hFF, 4'hF, 1'b0);
            n_cmp++;
            if (fetch_req !== 1'b0 || vid !== 2'd0 || underrun !== 1'b0) begin
                n_err++; $display("FAIL mid_idle cyc=%0d got req=%0b vid=%0d und=%0b want 0/0/0", i, fetch_req, vid, underrun);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        h_half = 1'b1; line_start = 1'b0; fetch_ack = 1'b0; flip_x = 1'b0;
        plane0 = '0; plane1 = '0; color = '0;
        model_reset();
        test_reset();
        test_pattern(1'b0, 16'hDD88);
        test_pattern(1'b1, 16'h2277);
        test_bypass();
        test_ls_ack();
        test_underrun();
        test_random();
        test_reset_midline();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
